// File: rtl/keyscan_pkg.sv
// Shared constants, scan FSM state encoding and row-drive helper for the key matrix scanner.
package keyscan_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int NKEYS = ROWS * COLS;

    typedef logic [1:0] scan_state_t;

    localparam scan_state_t DRIVE  = 2'd0;
    localparam scan_state_t SAMPLE = 2'd1;
    localparam scan_state_t NEXT   = 2'd2;

    function automatic logic [ROWS-1:0] row_drive(input logic [1:0] r);
        return ~(4'b0001 << r);
    endfunction

endpackage

// File: rtl/key_matrix_scan_debounce.sv
// Per-key frame-rate debouncer: a key flips only after DEBOUNCE_SCANS consecutive disagreeing frames.
// Optional press pulse output when KEYSCAN_EVENT_EN is defined.
module key_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic CLK,
    input  logic rst,
    input  logic update,
    input  logic raw,
    output logic key
`ifdef KEYSCAN_EVENT_EN
    ,
    output logic press
`endif
);

    localparam logic [3:0] THRESH_M1 = 4'(DEBOUNCE_SCANS - 1);

    logic [3:0] cnt;

    // Any agreeing frame restarts the count, so a bounce never accumulates.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            key <= 1'b1;
            cnt <= 4'd0;
        end else if (update) begin
            if (raw == key) begin
                cnt <= 4'd0;
            end else if (cnt == THRESH_M1) begin
                key <= raw;
                cnt <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

`ifdef KEYSCAN_EVENT_EN
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            press <= 1'b0;
        end else begin
            press <= update && key && !raw && (cnt == THRESH_M1);
        end
    end
`endif

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 key matrix scanner with per-key frame debouncing.
// Define KEYSCAN_EVENT_EN to add the press_evt one-cycle press pulses.
module key_matrix_scan
    import keyscan_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             CLK,
    input  logic             rst,
    output logic [ROWS-1:0]  row_n,
    input  logic [COLS-1:0]  col_n,
    output logic [NKEYS-1:0] keys,
    output logic             scan_done
`ifdef KEYSCAN_EVENT_EN
    ,
    output logic [NKEYS-1:0] press_evt
`endif
);

    logic [COLS-1:0]  col_s1;
    logic [COLS-1:0]  col_s2;
    scan_state_t      state;
    logic [1:0]       row;
    logic [15:0]      div_cnt;
    logic [NKEYS-1:0] raw;
    logic             frame_tick;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            col_s1 <= '1;
            col_s2 <= '1;
        end else begin
            col_s1 <= col_n;
            col_s2 <= col_s1;
        end
    end

    // Reset parks in DRIVE with div_cnt = 0 so the first edge starts row 0 cleanly.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state   <= DRIVE;
            row     <= 2'd0;
            div_cnt <= 16'd0;
            row_n   <= '1;
            raw     <= '1;
        end else begin
            case (state)
                DRIVE: begin
                    row_n <= row_drive(row);
                    if (div_cnt == 16'(SCAN_DIV - 1)) begin
                        state <= SAMPLE;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                SAMPLE: begin
                    for (int c = 0; c < COLS; c++) begin
                        raw[{row, 2'(c)}] <= col_s2[c];
                    end
                    row_n <= '1;
                    state <= NEXT;
                end
                NEXT: begin
                    row     <= row + 2'd1;
                    row_n   <= row_drive(row + 2'd1);
                    div_cnt <= 16'd1;
                    state   <= DRIVE;
                end
                default: begin
                    row     <= 2'd0;
                    div_cnt <= 16'd0;
                    row_n   <= '1;
                    state   <= DRIVE;
                end
            endcase
        end
    end

    assign frame_tick = (state == NEXT) && (row == 2'd3);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            scan_done <= 1'b0;
        end else begin
            scan_done <= frame_tick;
        end
    end

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_debounce (
            .CLK   (CLK),
            .rst   (rst),
            .update(frame_tick),
            .raw   (raw[i]),
            .key   (keys[i])
`ifdef KEYSCAN_EVENT_EN
            ,
            .press (press_evt[i])
`endif
        );
    end

endmodule
